bit_permute_pipe: RTL and testbench

BIT_PERMUTE_PIPE -- requirements
Module: bit_permute_pipe

---
 rtl/bit_permute_pipe.sv | 85 ++++++++
 tb/tb_bit_permute_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_permute_pipe.sv
// Two-stage bit-permutation pipeline: S1 registers the word and its mode, S2 registers
// the permuted result. Holds up to two words under backpressure; counts output transfers.
module bit_permute_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4,
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_mode,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic [CNT_W-1:0]         xfer_count
);

  localparam int NG = WIDTH / GROUP;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'b00,
    MODE_REV      = 2'b01,
    MODE_GRP_REV  = 2'b10,
    MODE_GRP_SWAP = 2'b11
  } mode_t;

  logic                   s1_valid;
  logic [LANES*WIDTH-1:0] s1_data;
  mode_t                  s1_mode;
  logic                   s2_valid;
  logic [LANES*WIDTH-1:0] s2_data;
  logic [LANES*WIDTH-1:0] perm;
  logic [CNT_W-1:0]       count;
  logic                   s1_load;
  logic                   s2_load;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  // Equivalent to (S1 empty) | (S2 empty) | out_ready.
  assign in_ready = s1_load;

  // Each output bit is a 4:1 mux over constant source positions.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int GI = i / GROUP;
      localparam int JI = i % GROUP;
      localparam int B  = k * WIDTH;
      assign perm[B+i] =
        (s1_mode == MODE_PASS)    ? s1_data[B+i] :
        (s1_mode == MODE_REV)     ? s1_data[B+WIDTH-1-i] :
        (s1_mode == MODE_GRP_REV) ? s1_data[B+GI*GROUP+GROUP-1-JI] :
                                    s1_data[B+(NG-1-GI)*GROUP+JI];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_PASS;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      count    <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        s1_data  <= in_data;
        s1_mode  <= mode_t'(in_mode);
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= perm;
      end
      if (s2_valid && out_ready) count <= count + 1'b1;
    end
  end

  assign out_valid  = s2_valid;
  assign out_data   = s2_data;
  assign xfer_count = count;

endmodule

// File: tb/tb_bit_permute_pipe.sv
// Self-checking bench for bit_permute_pipe: directed cases plus random traffic against
// a capacity-2 FIFO model with arithmetic permutation reference.
module tb_bit_permute_pipe;
  localparam int W  = 8;
  localparam int G  = 4;
  localparam int L  = 2;
  localparam int NG = W / G;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [1:0]     in_mode;
  logic [L*W-1:0] in_data, out_data;
  logic [15:0]    cnt16;
  logic           in_ready4, out_valid4;
  logic [L*W-1:0] out_data4;
  logic [3:0]     cnt4;

  always #5 clk = ~clk;

  bit_permute_pipe #(.WIDTH(W), .GROUP(G), .LANES(L), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .xfer_count(cnt16));

  bit_permute_pipe #(.WIDTH(W), .GROUP(G), .LANES(L), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .xfer_count(cnt4));

  typedef struct {
    logic [L*W-1:0] d;
    logic [1:0]     m;
    int             acc;
  } word_t;

  word_t q[$];
  int    edge_now = 0;
  int    exp_cnt  = 0;
  int    n_assert = 0;
  int    n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev_bits(input int v, input int n);
    int r = 0;
    int x = v;
    for (int k = 0; k < n; k++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] ref_lane(input logic [W-1:0] x, input logic [1:0] m);
    int v    = int'(x);
    int r    = 0;
    int span = 1 << G;
    int gv;
    case (m)
      2'd0: r = v;
      2'd1: r = rev_bits(v, W);
      2'd2: for (int g = 0; g < NG; g++) begin
              gv = (v >> (g * G)) % span;
              r  = r + (rev_bits(gv, G) << (g * G));
            end
      default: for (int g = 0; g < NG; g++) begin
              gv = (v >> (g * G)) % span;
              r  = r + (gv << ((NG - 1 - g) * G));
            end
    endcase
    return r[W-1:0];
  endfunction

  function automatic logic [L*W-1:0] ref_word(input logic [L*W-1:0] d, input logic [1:0] m);
    logic [L*W-1:0] res = '0;
    for (int k = 0; k < L; k++) res[k*W +: W] = ref_lane(d[k*W +: W], m);
    return res;
  endfunction

  // One clock cycle: drive at negedge, check against the model, advance model at posedge.
  task automatic cycle(input logic v, input logic [1:0] m, input logic [L*W-1:0] d,
                       input logic ordy, output logic acc);
    logic exp_ov, exp_ir, out_fire;
    @(negedge clk);
    in_valid = v; in_mode = m; in_data = d; out_ready = ordy;
    #1;
    exp_ov = (q.size() > 0) && (edge_now - q[0].acc >= 1);
    exp_ir = (q.size() < 2) || ordy;
    chk("out_valid", out_valid, exp_ov);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid4", out_valid4, exp_ov);
    chk("in_ready4", in_ready4, exp_ir);
    if (exp_ov) begin
      chk("out_data", out_data, ref_word(q[0].d, q[0].m));
      chk("out_data4", out_data4, ref_word(q[0].d, q[0].m));
    end
    chk("xfer_count", cnt16, exp_cnt % 65536);
    chk("xfer_count4", cnt4, exp_cnt % 16);
    acc      = v && exp_ir;
    out_fire = exp_ov && ordy;
    @(posedge clk);
    edge_now++;
    if (out_fire) begin
      void'(q.pop_front());
      exp_cnt++;
    end
    if (acc) q.push_back('{d, m, edge_now});
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_count", cnt16, '0);
    chk("rst_count4", cnt4, '0);
    q.delete();
    exp_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    logic a;
    for (int n = 0; n < limit && q.size() > 0; n++) cycle(1'b0, 2'd0, '0, 1'b1, a);
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic           a;
    logic [L*W-1:0] w [3];
    logic [1:0]     md  [3] = '{2'd2, 2'd3, 2'd0};
    logic [7:0]     exl [3] = '{8'h8C, 8'h31, 8'h13};
    int             idx;

    rst = 1'b1; in_valid = 1'b0; in_mode = 2'd0; in_data = '0; out_ready = 1'b0;
    #1;
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_out_data", out_data, '0);
    chk("init_in_ready", in_ready, 1'b1);
    chk("init_count", cnt16, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Full bit reverse, two-edge latency
    cycle(1'b1, 2'b01, 16'b10110000_00000001, 1'b1, a);
    cycle(1'b0, 2'b00, '0, 1'b1, a);
    chk("rev_valid", out_valid, 1'b1);
    chk("rev_data", out_data, 16'b00001101_10000000);
    drain(4);

    // Group modes on lane0 = 00010011
    for (int t = 0; t < 3; t++) begin
      cycle(1'b1, md[t], {8'($urandom), 8'h13}, 1'b1, a);
      cycle(1'b0, 2'd0, '0, 1'b1, a);
      chk("grp_lane0", out_data[7:0], exl[t]);
      drain(4);
    end

    // Back-to-back mode changes
    for (int t = 0; t < 4; t++) cycle(1'b1, 2'(t + 1), 16'($urandom), 1'b1, a);
    drain(6);

    // Backpressure: buffer two, stall the third, then drain in order
    do_reset();
    for (int t = 0; t < 3; t++) w[t] = 16'($urandom);
    idx = 0;
    for (int n = 0; n < 3; n++) begin
      cycle(1'b1, 2'b01, w[idx], 1'b0, a);
      if (a) idx++;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", in_ready, 1'b0);
    for (int n = 0; n < 4 && idx < 3; n++) begin
      cycle(1'b1, 2'b01, w[idx], 1'b1, a);
      if (a) idx++;
    end
    chk("bp_accepted_all", idx, 3);
    drain(6);
    chk("bp_count", cnt16, 16'd3);

    // Async reset with two words in flight
    cycle(1'b1, 2'b10, 16'($urandom), 1'b0, a);
    cycle(1'b1, 2'b11, 16'($urandom), 1'b0, a);
    chk("inflight", q.size(), 2);
    do_reset();
    for (int n = 0; n < 4; n++) cycle(1'b0, 2'd0, '0, 1'b1, a);
    cycle(1'b1, 2'b11, 16'hA5C3, 1'b1, a);
    cycle(1'b0, 2'd0, '0, 1'b1, a);
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_data", out_data, 16'h5A3C);
    drain(4);

    // Random traffic
    for (int n = 0; n < 400; n++)
      cycle(($urandom % 4) != 0, 2'($urandom), 16'($urandom), ($urandom % 3) != 0, a);
    drain(8);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int n = 0; n < 17; n++) begin
      cycle(1'b1, 2'($urandom), 16'($urandom), 1'b1, a);
      if (exp_cnt == 15) chk("wrap_15", cnt4, 4'd15);
      if (exp_cnt == 16) chk("wrap_16", cnt4, 4'd0);
    end
    for (int n = 0; n < 4 && q.size() > 0; n++) begin
      cycle(1'b0, 2'd0, '0, 1'b1, a);
      if (exp_cnt == 16) chk("wrap_16", cnt4, 4'd0);
      if (exp_cnt == 17) chk("wrap_17", cnt4, 4'd1);
    end
    chk("wrap_total", cnt16, 16'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
